// File: rtl/board_input_conditioner_pkg.sv
// Shared types and default constants for the board input conditioner.
//   deb_state_t      : per-channel debounce FSM state
//   DEF_N_CH         : default channel count
//   DEF_DEB_CYCLES   : default stability window (10 ms at 100 MHz)
//   DEF_SYNC_STAGES  : default synchroniser depth
package board_io_pkg;

    localparam int unsigned DEF_N_CH        = 16;
    localparam int unsigned DEF_DEB_CYCLES  = 1_000_000;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_t;

endpackage

// File: rtl/board_input_conditioner_if.sv
// Bus between the pad side and the input conditioner.
//   master : drives raw_i / mask_i / clr_i, observes conditioned outputs
//   slave  : the conditioner itself
interface board_input_conditioner_if
    import board_io_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH
);
    logic [N_CH-1:0] raw_i;
    logic [N_CH-1:0] mask_i;
    logic [N_CH-1:0] clr_i;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] rise_o;
    logic [N_CH-1:0] fall_o;
    logic [N_CH-1:0] sticky_o;
    logic            any_event_o;

    modport master (
        output raw_i, mask_i, clr_i,
        input  level_o, rise_o, fall_o, sticky_o, any_event_o
    );

    modport slave (
        input  raw_i, mask_i, clr_i,
        output level_o, rise_o, fall_o, sticky_o, any_event_o
    );
endinterface

// File: rtl/board_input_conditioner_debounce.sv
// One input channel: synchroniser, debounce FSM with stability counter, edge pulses.
//   clk, rst : clock, async active-high reset
//   raw      : asynchronous pad input
//   mask     : suppresses rise/fall pulses only
//   level    : debounced level
//   rise     : one-cycle pulse when level goes 0->1 (unmasked)
//   fall     : one-cycle pulse when level goes 1->0 (unmasked)
module debounce_ch
    import board_io_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic mask,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    // The WAIT entry cycle already counts as the first stable sample, so the
    // window closes when the counter is about to reach DEB_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEB_CYCLES - 2);
    localparam deb_state_t       RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_t             state;
    logic [CNT_W-1:0]       cnt;

    assign sync = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser, shifts towards the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce FSM, counter and registered edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
            cnt   <= '0;
            level <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (sync) begin
                        state <= WAIT_HI;
                        cnt   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= ~mask;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!sync) begin
                        state <= WAIT_LO;
                        cnt   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (sync) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= ~mask;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= RESET_STATE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/board_input_conditioner.sv
// Debounces N_CH board switches/buttons and latches rising events.
//   clk100mhz : 100 MHz board clock
//   rst       : async active-high reset
//   bus       : slave side of board_input_conditioner_if
//               (raw_i, mask_i, clr_i in; level_o, rise_o, fall_o, sticky_o, any_event_o out)
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned     N_CH        = DEF_N_CH,
    parameter int unsigned     DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned     SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [N_CH-1:0] RESET_LEVEL = '0
) (
    input  logic                      clk100mhz,
    input  logic                      rst,
    board_input_conditioner_if.slave  bus
);
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] sticky;
    logic            any_event;

    // Independent per-channel debouncers
    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        debounce_ch #(
            .DEB_CYCLES  (DEB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_LEVEL (RESET_LEVEL[g])
        ) u_ch (
            .clk   (clk100mhz),
            .rst   (rst),
            .raw   (bus.raw_i[g]),
            .mask  (bus.mask_i[g]),
            .level (level[g]),
            .rise  (rise[g]),
            .fall  (fall[g])
        );
    end

    // Sticky rise latch (set beats clear) and its registered OR summary
    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            sticky    <= '0;
            any_event <= 1'b0;
        end else begin
            sticky    <= (sticky & ~bus.clr_i) | rise;
            any_event <= |sticky;
        end
    end

    assign bus.level_o     = level;
    assign bus.rise_o      = rise;
    assign bus.fall_o      = fall;
    assign bus.sticky_o    = sticky;
    assign bus.any_event_o = any_event;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Randomised and directed bench for board_input_conditioner (N_CH=4, DEB_CYCLES=4,
// SYNC_STAGES=2, RESET_LEVEL=0) against a history-based reference model.
module tb_board_input_conditioner;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned DEB_CYCLES  = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [N_CH-1:0] RESET_LEVEL = '0;

    logic clk = 1'b0;
    logic rst;

    board_input_conditioner_if #(.N_CH(N_CH)) bus();

    board_input_conditioner #(
        .N_CH        (N_CH),
        .DEB_CYCLES  (DEB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) dut (
        .clk100mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: raw samples taken at each edge since reset
    logic [N_CH-1:0] raw_hist[$];
    logic [N_CH-1:0] m_level;
    logic [N_CH-1:0] m_rise;
    logic [N_CH-1:0] m_fall;
    logic [N_CH-1:0] m_sticky;
    logic            m_any;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Synchronised value visible after edge j: the raw sample of edge j-SYNC_STAGES+1
    function automatic logic [N_CH-1:0] sync_after(input int j);
        int e;
        e = j - int'(SYNC_STAGES) + 1;
        if (e >= 1) return raw_hist[e-1];
        return RESET_LEVEL;
    endfunction

    task automatic model_reset();
        raw_hist.delete();
        m_level  = RESET_LEVEL;
        m_rise   = '0;
        m_fall   = '0;
        m_sticky = '0;
        m_any    = 1'b0;
    endtask

    // Level flips at edge n once the previous DEB_CYCLES synchronised samples all differ from it
    task automatic model_step();
        int n;
        logic [N_CH-1:0] s;
        logic [N_CH-1:0] flip;
        logic [N_CH-1:0] nlevel;
        n = raw_hist.size() + 1;
        flip = '1;
        for (int d = 1; d <= int'(DEB_CYCLES); d++) begin
            s = sync_after(n - d);
            flip &= (s ^ m_level);
        end
        nlevel   = m_level ^ flip;
        m_any    = |m_sticky;
        m_sticky = (m_sticky & ~bus.clr_i) | m_rise;
        m_rise   = flip & nlevel & ~bus.mask_i;
        m_fall   = flip & ~nlevel & ~bus.mask_i;
        m_level  = nlevel;
        raw_hist.push_back(bus.raw_i);
    endtask

    // One clock: update model from inputs at the edge, compare just after it
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        chk("level",  32'(bus.level_o),     32'(m_level));
        chk("rise",   32'(bus.rise_o),      32'(m_rise));
        chk("fall",   32'(bus.fall_o),      32'(m_fall));
        chk("sticky", 32'(bus.sticky_o),    32'(m_sticky));
        chk("any",    32'(bus.any_event_o), 32'(m_any));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.raw_i  = '0;
        bus.mask_i = '0;
        bus.clr_i  = '0;
        model_reset();
        #1;
        chk("async_reset_level", 32'(bus.level_o), 32'(RESET_LEVEL));
        do_reset(3);

        // Quiet inputs: everything stays low
        repeat (20) tick();
        chk("quiet_sticky", 32'(bus.sticky_o), 32'd0);

        // Clean rise on ch0: level exactly 6 edges after the first sampling edge
        bus.raw_i[0] = 1'b1;
        repeat (5) tick();
        chk("ch0_level_edge5", 32'(bus.level_o[0]), 32'd0);
        tick();
        chk("ch0_level_edge6", 32'(bus.level_o[0]), 32'd1);
        chk("ch0_rise_edge6",  32'(bus.rise_o[0]),  32'd1);
        tick();
        chk("ch0_rise_gone",   32'(bus.rise_o[0]),  32'd0);
        chk("ch0_sticky",      32'(bus.sticky_o[0]), 32'd1);
        chk("any_lags",        32'(bus.any_event_o), 32'd0);
        tick();
        chk("any_set",         32'(bus.any_event_o), 32'd1);

        // Short pulse on ch1 is filtered
        bus.raw_i[1] = 1'b1;
        repeat (3) tick();
        bus.raw_i[1] = 1'b0;
        repeat (10) tick();
        chk("ch1_pulse_level",  32'(bus.level_o[1]),  32'd0);
        chk("ch1_pulse_sticky", 32'(bus.sticky_o[1]), 32'd0);

        // Clear coinciding with a new rise: set wins, then a lone clear drops it
        bus.raw_i[0] = 1'b0;
        repeat (8) tick();
        bus.raw_i[0] = 1'b1;
        for (int i = 0; i < 20 && !m_rise[0]; i++) tick();
        chk("ch0_rerise", 32'(bus.rise_o[0]), 32'd1);
        bus.clr_i[0] = 1'b1;
        tick();
        chk("set_beats_clear", 32'(bus.sticky_o[0]), 32'd1);
        tick();
        chk("clear_alone", 32'(bus.sticky_o[0]), 32'd0);
        bus.clr_i[0] = 1'b0;
        repeat (3) tick();

        // Masked channel still debounces but reports nothing
        bus.mask_i[2] = 1'b1;
        bus.raw_i[2]  = 1'b1;
        repeat (6) tick();
        chk("ch2_masked_level", 32'(bus.level_o[2]), 32'd1);
        repeat (3) tick();
        chk("ch2_masked_sticky", 32'(bus.sticky_o[2]), 32'd0);
        bus.mask_i[2] = 1'b0;

        // Reset in the middle of WAIT_HI on ch3
        bus.raw_i = '0;
        repeat (10) tick();
        do_reset(2);
        bus.raw_i[3] = 1'b1;
        repeat (4) tick();
        do_reset(2);
        repeat (5) tick();
        chk("ch3_level_after_rst5", 32'(bus.level_o[3]), 32'd0);
        tick();
        chk("ch3_level_after_rst6", 32'(bus.level_o[3]), 32'd1);
        chk("ch3_rise_after_rst",   32'(bus.rise_o[3]),  32'd1);

        // Random phase: slow-toggling raw lines, random mask/clear, occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < int'(N_CH); b++) begin
                if ($urandom_range(0, 5) == 0) bus.raw_i[b] = ~bus.raw_i[b];
                bus.mask_i[b] = ($urandom_range(0, 3) == 0);
                bus.clr_i[b]  = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                tick();
            end
        end

        // All channels change together and report in the same cycle
        bus.mask_i = '0;
        bus.clr_i  = '0;
        bus.raw_i  = '0;
        do_reset(2);
        bus.raw_i = '1;
        repeat (6) tick();
        chk("all_rise_together", 32'(bus.rise_o), 32'hF);
        bus.raw_i = '0;
        repeat (6) tick();
        chk("all_fall_together", 32'(bus.fall_o), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
